wb_arbiter: RTL and testbench

// Shares the single register-file write-back port (tag, rd, data) among NUM_SRC execution units (ALU, LSU, branch).

---
 rtl/wb_arbiter_pkg.sv | 26 ++
 rtl/wb_src_fifo.sv | 65 ++++++
 rtl/wb_arbiter.sv | 108 ++++++++++
 tb/tb_wb_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter: beat payload,
// idle tag encoding and source indices.
package wb_arbiter_pkg;

  localparam int unsigned NUM_SRC    = 3;
  localparam int unsigned DEPTH      = 2;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned TAG_W      = 4;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [TAG_W-1:0] TAG_INVALID = '1;

  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_LSU = 1;
  localparam int unsigned SRC_BR  = 2;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_beat_t;

  // Value the bus carries whenever no beat is valid
  localparam wb_beat_t WB_IDLE = '{tag: TAG_INVALID, rd: '0, data: '0};

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO; flush empties it and drops a concurrent push.
module wb_src_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     push,
  input  wb_beat_t push_beat,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output wb_beat_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_beat_t         mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem_q[wr_ptr_q] <= push_beat;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: drains one buffered result per cycle from
// NUM_SRC source FIFOs onto a registered write-back bus.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = wb_arbiter_pkg::NUM_SRC,
  parameter int unsigned DEPTH   = wb_arbiter_pkg::DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]     src_tag,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  output logic                         wb_valid,
  output logic [TAG_W-1:0]             wb_tag,
  output logic [REG_ADDR_W-1:0]        wb_rd,
  output logic [DATA_W-1:0]            wb_data
);

  localparam int unsigned RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] full, empty, push;
  wb_beat_t           push_beat [NUM_SRC];
  wb_beat_t           head      [NUM_SRC];

  logic [NUM_SRC-1:0] req_c, mask_c, hi_c, sel_c, grant_c;
  logic               found_c;
  logic [RR_W-1:0]    win_c, rr_next_c;
  wb_beat_t           win_beat_c;

  // Running OR chains turn the one-hot grant into an index and a payload
  logic     [NUM_SRC:0][RR_W-1:0] idx_chain;
  wb_beat_t [NUM_SRC:0]           beat_chain;

  logic            wb_valid_q;
  wb_beat_t        wb_beat_q;
  logic [RR_W-1:0] rr_ptr_q;

  assign idx_chain[0]  = '0;
  assign beat_chain[0] = '0;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign push_beat[g] = '{tag:  src_tag[g*TAG_W +: TAG_W],
                            rd:   src_rd[g*REG_ADDR_W +: REG_ADDR_W],
                            data: src_data[g*DATA_W +: DATA_W]};
    // rd==0 completes the handshake but is never stored
    assign push[g] = src_valid[g] & ~full[g] &
                     (src_rd[g*REG_ADDR_W +: REG_ADDR_W] != '0);

    wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push[g]),
      .push_beat (push_beat[g]),
      .pop       (grant_c[g]),
      .full      (full[g]),
      .empty     (empty[g]),
      .head      (head[g])
    );

    assign idx_chain[g+1]  = idx_chain[g]  | (grant_c[g] ? RR_W'(g) : '0);
    assign beat_chain[g+1] = beat_chain[g] | (grant_c[g] ? head[g] : '0);
  end

  assign src_ready = ~full;

  // Masked priority: prefer requesters at or above rr_ptr, else wrap to the lowest
  always_comb begin
    req_c      = ~empty;
    mask_c     = ~((NUM_SRC'(1) << rr_ptr_q) - NUM_SRC'(1));
    hi_c       = req_c & mask_c;
    sel_c      = (hi_c != '0) ? hi_c : req_c;
    grant_c    = sel_c & (~sel_c + NUM_SRC'(1));
    found_c    = (req_c != '0);
    win_c      = idx_chain[NUM_SRC];
    win_beat_c = beat_chain[NUM_SRC];
    rr_next_c  = rr_ptr_q;
    if (found_c) begin
      rr_next_c = (win_c == RR_W'(NUM_SRC - 1)) ? '0 : win_c + RR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_beat_q  <= WB_IDLE;
      rr_ptr_q   <= '0;
    end else if (flush) begin
      wb_valid_q <= 1'b0;
      wb_beat_q  <= WB_IDLE;
      rr_ptr_q   <= '0;
    end else begin
      wb_valid_q <= found_c;
      wb_beat_q  <= found_c ? win_beat_c : WB_IDLE;
      rr_ptr_q   <= rr_next_c;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_tag   = wb_beat_q.tag;
  assign wb_rd    = wb_beat_q.rd;
  assign wb_data  = wb_beat_q.data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus hand-built stall and flush sequences.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [11:0] src_tag;
  logic [14:0] src_rd;
  logic [95:0] src_data;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_tag   (src_tag),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [2:0]  vld;
    logic [11:0] tag;
    logic [14:0] rd;
    logic [95:0] data;
    logic        ev;
    logic [3:0]  et;
    logic [4:0]  er;
    logic [31:0] ed;
    logic [2:0]  erdy;
  } vec_t;

  vec_t vecs [$];

  int alu_t [4] = '{8, 9, 10, 11};
  int lsu_t [3] = '{4, 5, 6};
  logic [3:0] s4_tag [9] = '{4'hF, 4'd8, 4'd4, 4'd9, 4'd5, 4'd10, 4'd6, 4'd11, 4'hF};
  logic [2:0] s4_rdy [9] = '{3'b111, 3'b101, 3'b110, 3'b101, 3'b110,
                             3'b111, 3'b111, 3'b111, 3'b111};

  function automatic vec_t mk(logic fl, logic [2:0] vld, logic [11:0] tag,
                              logic [14:0] rd, logic [95:0] data, logic ev,
                              logic [3:0] et, logic [4:0] er, logic [31:0] ed,
                              logic [2:0] erdy);
    vec_t v;
    v.fl = fl; v.vld = vld; v.tag = tag; v.rd = rd; v.data = data;
    v.ev = ev; v.et = et; v.er = er; v.ed = ed; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; src_valid = '0; src_tag = '0; src_rd = '0; src_data = '0;
  endtask

  // Idle bus must be clean, and a rd==0 push (tag 7) must never surface
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (!wb_valid) begin
        total++;
        if (wb_tag !== TAG_INVALID || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
          bad++;
          $display("FAIL idle_bus actual=%0h/%0h/%0h required=%0h/0/0",
                   wb_tag, wb_rd, wb_data, TAG_INVALID);
        end
      end else begin
        total++;
        if (wb_tag === 4'd7) begin
          bad++;
          $display("FAIL rd0_leak actual tag=%0h required not 7", wb_tag);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle_inputs();

    // Reset held two cycles, then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_tag",   32'(wb_tag),   32'(TAG_INVALID));
    chk("rst_rd",    32'(wb_rd),    32'd0);
    chk("rst_data",  wb_data,       32'd0);
    chk("rst_ready", 32'(src_ready), 32'b111);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle_valid_%0d", i), 32'(wb_valid), 32'd0);
    end

    // Single ALU beat, flush to rr 0, three-way push, rd==0 push, rr ordering
    vecs.push_back(mk(0, 3'b001, {4'd0, 4'd0, 4'd2}, {5'd0, 5'd0, 5'd5},
                      {32'd0, 32'd0, 32'hDEAD}, 0, 4'hF, 5'd0, 32'd0, 3'b111));
    vecs.push_back(mk(0, 3'b000, '0, '0, '0, 1, 4'd2, 5'd5, 32'hDEAD, 3'b111));
    vecs.push_back(mk(0, 3'b000, '0, '0, '0, 0, 4'hF, 5'd0, 32'd0, 3'b111));
    vecs.push_back(mk(1, 3'b000, '0, '0, '0, 0, 4'hF, 5'd0, 32'd0, 3'b111));
    vecs.push_back(mk(0, 3'b111, {4'd3, 4'd2, 4'd1}, {5'd3, 5'd2, 5'd1},
                      {32'h33, 32'h22, 32'h11}, 0, 4'hF, 5'd0, 32'd0, 3'b111));
    vecs.push_back(mk(0, 3'b000, '0, '0, '0, 1, 4'd1, 5'd1, 32'h11, 3'b111));
    vecs.push_back(mk(0, 3'b000, '0, '0, '0, 1, 4'd2, 5'd2, 32'h22, 3'b111));
    vecs.push_back(mk(0, 3'b000, '0, '0, '0, 1, 4'd3, 5'd3, 32'h33, 3'b111));
    vecs.push_back(mk(0, 3'b000, '0, '0, '0, 0, 4'hF, 5'd0, 32'd0, 3'b111));
    vecs.push_back(mk(0, 3'b001, {4'd0, 4'd0, 4'd7}, {5'd0, 5'd0, 5'd0},
                      {32'd0, 32'd0, 32'h77}, 0, 4'hF, 5'd0, 32'd0, 3'b111));
    vecs.push_back(mk(0, 3'b000, '0, '0, '0, 0, 4'hF, 5'd0, 32'd0, 3'b111));
    vecs.push_back(mk(0, 3'b000, '0, '0, '0, 0, 4'hF, 5'd0, 32'd0, 3'b111));
    vecs.push_back(mk(0, 3'b011, {4'd0, 4'd4, 4'd5}, {5'd0, 5'd4, 5'd6},
                      {32'd0, 32'h44, 32'h55}, 0, 4'hF, 5'd0, 32'd0, 3'b111));
    vecs.push_back(mk(0, 3'b000, '0, '0, '0, 1, 4'd5, 5'd6, 32'h55, 3'b111));
    vecs.push_back(mk(0, 3'b000, '0, '0, '0, 1, 4'd4, 5'd4, 32'h44, 3'b111));
    vecs.push_back(mk(0, 3'b000, '0, '0, '0, 0, 4'hF, 5'd0, 32'd0, 3'b111));
    vecs.push_back(mk(1, 3'b000, '0, '0, '0, 0, 4'hF, 5'd0, 32'd0, 3'b111));

    foreach (vecs[i]) begin
      flush     = vecs[i].fl;
      src_valid = vecs[i].vld;
      src_tag   = vecs[i].tag;
      src_rd    = vecs[i].rd;
      src_data  = vecs[i].data;
      tick();
      chk($sformatf("v%0d_valid", i), 32'(wb_valid),  32'(vecs[i].ev));
      chk($sformatf("v%0d_tag", i),   32'(wb_tag),    32'(vecs[i].et));
      chk($sformatf("v%0d_rd", i),    32'(wb_rd),     32'(vecs[i].er));
      chk($sformatf("v%0d_data", i),  wb_data,        vecs[i].ed);
      chk($sformatf("v%0d_ready", i), 32'(src_ready), 32'(vecs[i].erdy));
    end
    idle_inputs();

    // LSU streams 3 beats against a 4-beat ALU stream; sources honour ready
    begin
      int ai = 0;
      int li = 0;
      for (int c = 0; c < 9; c++) begin
        logic [2:0] rdy;
        rdy = src_ready;
        idle_inputs();
        if (ai < 4) begin
          src_valid[SRC_ALU] = 1'b1;
          src_tag[SRC_ALU*4 +: 4]   = 4'(alu_t[ai]);
          src_rd[SRC_ALU*5 +: 5]    = 5'(alu_t[ai]);
          src_data[SRC_ALU*32 +: 32] = 32'h100 + 32'(alu_t[ai]);
        end
        if (li < 3) begin
          src_valid[SRC_LSU] = 1'b1;
          src_tag[SRC_LSU*4 +: 4]   = 4'(lsu_t[li]);
          src_rd[SRC_LSU*5 +: 5]    = 5'(lsu_t[li]);
          src_data[SRC_LSU*32 +: 32] = 32'h200 + 32'(lsu_t[li]);
        end
        tick();
        if (src_valid[SRC_ALU] && rdy[SRC_ALU]) ai++;
        if (src_valid[SRC_LSU] && rdy[SRC_LSU]) li++;
        chk($sformatf("s4_c%0d_valid", c), 32'(wb_valid), 32'(s4_tag[c] != 4'hF));
        chk($sformatf("s4_c%0d_tag", c),   32'(wb_tag),   32'(s4_tag[c]));
        chk($sformatf("s4_c%0d_ready", c), 32'(src_ready), 32'(s4_rdy[c]));
      end
      chk("s4_alu_sent", 32'(ai), 32'd4);
      chk("s4_lsu_sent", 32'(li), 32'd3);
    end
    idle_inputs();

    // Build four held beats, then flush with a concurrent LSU push
    src_valid = 3'b111;
    src_tag   = {4'd3, 4'd2, 4'd1};
    src_rd    = {5'd3, 5'd2, 5'd1};
    src_data  = {32'hA3, 32'hA2, 32'hA1};
    tick();
    chk("s5_fill0_valid", 32'(wb_valid), 32'd0);
    src_valid = 3'b101;
    src_tag   = {4'd6, 4'd0, 4'd4};
    src_rd    = {5'd6, 5'd0, 5'd4};
    src_data  = {32'hA6, 32'd0, 32'hA4};
    tick();
    chk("s5_fill1_tag",   32'(wb_tag),    32'd2);
    chk("s5_fill1_data",  wb_data,        32'hA2);
    chk("s5_fill1_ready", 32'(src_ready), 32'b010);
    idle_inputs();
    flush = 1'b1;
    src_valid = 3'b010;
    src_tag   = {4'd0, 4'd9, 4'd0};
    src_rd    = {5'd0, 5'd9, 5'd0};
    src_data  = {32'd0, 32'hA9, 32'd0};
    tick();
    chk("s5_flush_valid", 32'(wb_valid),  32'd0);
    chk("s5_flush_tag",   32'(wb_tag),    32'(TAG_INVALID));
    chk("s5_flush_ready", 32'(src_ready), 32'b111);
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("s5_post%0d_valid", i), 32'(wb_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
